piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer with a valid/ready word input and a one-word holding buffer.
//  Words stream out back-to-back with no idle bit between frames; bit order is selectable.
//  Paced by an external per-bit strobe (shift_en). Sits between the NVM read-data path and the serial pin driver.
// PARAMETERS
//  DATA_W      8  word width in bits; legal range >= 2
//  MSB_FIRST   1  1: bit DATA_W-1 is sent first; 0: bit 0 is sent first
//  IDLE_LEVEL  0  ser_out level whenever ser_valid=0
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  flush        in   1       synchronous abort; same effect as rst
//  in_valid     in   1       in_data valid
//  in_ready     out  1       buffer can accept a word
//  in_data      in   DATA_W  parallel word
//  shift_en     in   1       bit strobe; one bit is emitted per strobe while shifting
//  ser_out      out  1       serial data (registered)
//  ser_valid    out  1       ser_out carries a data bit this cycle
//  frame_start  out  1       1-cycle pulse, coincident with the first bit of a word
//  frame_done   out  1       1-cycle pulse, coincident with the last bit of a word
//  busy         out  1       state==SHIFT or hold_full
// BEHAVIOUR
//  - Reset/flush:
//    - state=IDLE; sreg, hold, cnt cleared; hold_full=0.
//    - ser_out=IDLE_LEVEL; ser_valid, frame_start, frame_done, busy = 0.
//    - in_ready=1 in the cycle after reset/flush.
//    - rst/flush take priority over every other event, including a mid-frame transfer; the partial word is discarded.
//  - Accept: accept = in_valid & in_ready; in_ready = !hold_full.
//    - An accepted word is written to hold (hold_full<=1), except in the bypass case below.
//  - IDLE, hold_full=1: at the next edge sreg<=hold, hold_full<=0, cnt<=0, state<=SHIFT.
//    - No bit is emitted on this edge.
//  - SHIFT, shift_en=1:
//    - ser_out<=current bit (sreg[DATA_W-1] if MSB_FIRST, else sreg[0]).
//    - ser_valid<=1; sreg shifts toward the emitted end with 0 fill; cnt<=cnt+1.
//    - frame_start<=(cnt==0); frame_done<=(cnt==DATA_W-1).
//  - Last bit (cnt==DATA_W-1 with shift_en), resolved in this order:
//    1. hold_full: sreg<=hold, hold_full<=0, cnt<=0, stay in SHIFT (gapless).
//    2. else if accept in the same cycle: bypass, sreg<=in_data, hold untouched, stay in SHIFT.
//    3. else state<=IDLE.
//  - SHIFT, shift_en=0: ser_valid<=0, ser_out<=IDLE_LEVEL, pulses<=0; sreg and cnt hold.
//  - shift_en is ignored in IDLE.
//  - Latency, shift_en tied high, idle block: accept at edge E0 -> load at E1 -> first bit visible after E2.
//  - Sustained rate: one word per DATA_W strobes.
//  - cnt width $clog2(DATA_W); cnt never exceeds DATA_W-1.
//  - All outputs except in_ready and busy are registered.
// STRUCTURE
//  - piso_pkg: state_t enum {IDLE, SHIFT}, plus a function bit_sel(sreg, msb_first) for the emit/shift direction.
//  - Single module; no sub-module. The holding buffer and bit counter are inline.
// TESTING
//  1. DATA_W=8, MSB_FIRST=1, shift_en=1, send 8'hA5.
//     -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
//     -> frame_start on the 1st bit, frame_done on the 8th; ser_valid low afterwards.
//  2. MSB_FIRST=0, send 8'hA5.
//     -> 1,0,1,0,0,1,0,1 (LSB first: bits 0..7 of A5 = 1,0,1,0,0,1,0,1).
//     -> Repeat with 8'h01 -> 1,0,0,0,0,0,0,0.
//  3. in_valid held high with words 8'hF0, 8'h0F, 8'h3C.
//     -> 24 consecutive ser_valid cycles with no gap.
//     -> in_ready low while hold_full.
//     -> frame_done on cycles 8, 16, 24.
//  4. shift_en toggling 1,0,1,0 with 8'hC3.
//     -> bits appear only on strobe cycles; ser_out=IDLE_LEVEL between them.
//     -> Frame completes after 8 strobes.
//  5. Assert flush after the 3rd bit of 8'hFF, with 8'h11 in hold.
//     -> next cycle: ser_valid=0, busy=0, in_ready=1.
//     -> A following 8'h80 serializes cleanly.
//  6. Word accepted exactly on the last-bit cycle with hold empty (bypass).
//     -> next word's first bit follows immediately, with no gap.
//     -> Repeat with rst asserted on that same cycle -> everything cleared, nothing emitted.

Source files
------------

// File: rtl/piso_pkg.sv
`default_nettype none
// piso_pkg: shared state encoding and bit-order helper for the PISO serializer.
package piso_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Picks the emitted end of the shift register given its two end bits.
   function automatic logic bit_sel(input logic sreg_msb, input logic sreg_lsb,
                                    input logic msb_first);
      return msb_first ? sreg_msb : sreg_lsb;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// piso_serializer: valid/ready word in, strobe-paced serial bits out, one-word hold buffer
// for gapless back-to-back frames.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int MSB_FIRST  = 1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              shift_en,
   output logic              ser_out,
   output logic              ser_valid,
   output logic              frame_start,
   output logic              frame_done,
   output logic              busy
);

   localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] sreg;
   logic [DATA_W-1:0] hold;
   logic              hold_full;
   logic [CNT_W-1:0]  cnt;

   logic              accept;
   logic              last_bit;
   logic              bypass;
   logic              cur_bit;
   logic [DATA_W-1:0] sreg_shifted;

   assign in_ready = !hold_full;
   assign accept   = in_valid && in_ready;
   assign busy     = (state == SHIFT) || hold_full;
   assign last_bit = (state == SHIFT) && shift_en && (cnt == CNT_LAST);
   // A word arriving on the last bit with nothing held goes straight into sreg.
   assign bypass   = last_bit && !hold_full && accept;
   assign cur_bit  = bit_sel(sreg[DATA_W-1], sreg[0], MSB_FIRST != 0);

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
      end else begin : g_lsb_first
         assign sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state       <= IDLE;
         sreg        <= '0;
         hold        <= '0;
         hold_full   <= 1'b0;
         cnt         <= '0;
         ser_out     <= IDLE_LEVEL;
         ser_valid   <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         if (accept && !bypass) begin
            hold      <= in_data;
            hold_full <= 1'b1;
         end

         case (state)
            IDLE: begin
               ser_out     <= IDLE_LEVEL;
               ser_valid   <= 1'b0;
               frame_start <= 1'b0;
               frame_done  <= 1'b0;
               if (hold_full) begin
                  sreg      <= hold;
                  hold_full <= 1'b0;
                  cnt       <= '0;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               if (shift_en) begin
                  ser_out     <= cur_bit;
                  ser_valid   <= 1'b1;
                  frame_start <= (cnt == '0);
                  frame_done  <= (cnt == CNT_LAST);
                  if (cnt == CNT_LAST) begin
                     cnt <= '0;
                     if (hold_full) begin
                        sreg      <= hold;
                        hold_full <= 1'b0;
                     end else if (accept) begin
                        sreg <= in_data;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     sreg <= sreg_shifted;
                     cnt  <= cnt + CNT_W'(1);
                  end
               end else begin
                  ser_out     <= IDLE_LEVEL;
                  ser_valid   <= 1'b0;
                  frame_start <= 1'b0;
                  frame_done  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// tb_piso_serializer: scoreboard bench driving an MSB-first and an LSB-first instance in lockstep.
module tb_piso_serializer;

   localparam int  W    = 8;
   localparam bit  IDLE = 1'b0;

   typedef struct packed {
      logic b;
      logic fs;
      logic fd;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         shift_en;
   logic         toggle_se;
   logic         se_level;

   logic in_ready_m, ser_out_m, ser_valid_m, frame_start_m, frame_done_m, busy_m;
   logic in_ready_l, ser_out_l, ser_valid_l, frame_start_l, frame_done_l, busy_l;

   exp_t q_m[$];
   exp_t q_l[$];

   int n_checks = 0;
   int n_pass   = 0;
   int vcount   = 0;
   int run      = 0;
   int last_run = 0;

   always #5 clk = ~clk;

   piso_serializer #(.DATA_W(W), .MSB_FIRST(1), .IDLE_LEVEL(IDLE)) u_msb (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_m),
      .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out_m), .ser_valid(ser_valid_m),
      .frame_start(frame_start_m), .frame_done(frame_done_m), .busy(busy_m)
   );

   piso_serializer #(.DATA_W(W), .MSB_FIRST(0), .IDLE_LEVEL(IDLE)) u_lsb (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_data(in_data), .shift_en(shift_en), .ser_out(ser_out_l), .ser_valid(ser_valid_l),
      .frame_start(frame_start_l), .frame_done(frame_done_l), .busy(busy_l)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // shift_en either follows se_level or toggles every cycle.
   always @(posedge clk) begin
      #1;
      shift_en = toggle_se ? ~shift_en : se_level;
   end

   always @(negedge clk) begin
      exp_t e;
      if (ser_valid_m) begin
         if (q_m.size() == 0) check("extra_bit_msb", 32'(1), 32'(0));
         else begin
            e = q_m.pop_front();
            check("bit_msb", 32'({ser_out_m, frame_start_m, frame_done_m}), 32'(e));
         end
         vcount++;
         run++;
      end else begin
         check("idle_msb", 32'({ser_out_m, frame_start_m, frame_done_m}), 32'({IDLE, 2'b00}));
         if (run != 0) last_run = run;
         run = 0;
      end
      if (ser_valid_l) begin
         if (q_l.size() == 0) check("extra_bit_lsb", 32'(1), 32'(0));
         else begin
            e = q_l.pop_front();
            check("bit_lsb", 32'({ser_out_l, frame_start_l, frame_done_l}), 32'(e));
         end
      end
   end

   task automatic push_word(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) begin
         q_m.push_back('{b: d[W-1-i], fs: (i == 0), fd: (i == W-1)});
         q_l.push_back('{b: d[i],     fs: (i == 0), fd: (i == W-1)});
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Entered and left at posedge+1; the word is accepted on the edge inside.
   task automatic send(input logic [W-1:0] d);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      while (!in_ready_m && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("send_timeout", 32'(0), 32'(1));
      push_word(d);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q_m.size() != 0 || busy_m || ser_valid_m) && n < 400) begin
         tick();
         n++;
      end
      if (n >= 400) check("drain_timeout", 32'(0), 32'(1));
      tick();
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, 32'(ser_valid_m), 32'(0));
      check({tag, "_busy"},  32'(busy_m),      32'(0));
      check({tag, "_ready"}, 32'(in_ready_m),  32'(1));
      check({tag, "_out"},   32'(ser_out_m),   32'(IDLE));
      check({tag, "_done"},  32'(frame_done_m), 32'(0));
   endtask

   initial begin
      int base;
      int n;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0;
      toggle_se = 1'b0; se_level = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      check_cleared("reset");

      // Single word, MSB and LSB orders, with first-bit latency.
      send(8'hA5);
      check("lat_e1_valid", 32'(ser_valid_m), 32'(0));
      check("lat_e1_busy",  32'(busy_m),      32'(1));
      tick();
      check("lat_e1b_valid", 32'(ser_valid_m), 32'(0));
      tick();
      check("lat_e2_valid", 32'(ser_valid_m),   32'(1));
      check("lat_e2_start", 32'(frame_start_m), 32'(1));
      drain();
      check("a5_after_valid", 32'(ser_valid_m), 32'(0));
      send(8'h01);
      drain();

      // Back-to-back words with in_valid held high.
      send(8'hF0);
      send(8'h0F);
      check("b2b_ready_low", 32'(in_ready_m), 32'(0));
      check("b2b_busy",      32'(busy_m),     32'(1));
      send(8'h3C);
      drain();
      check("b2b_run", 32'(last_run), 32'(24));

      // Strobe toggling.
      toggle_se = 1'b1;
      base = vcount;
      send(8'hC3);
      drain();
      check("toggle_bits", 32'(vcount - base), 32'(8));
      check("toggle_run",  32'(last_run),      32'(1));
      toggle_se = 1'b0;
      repeat (3) tick();

      // Flush mid-frame with a word in hold.
      base = vcount;
      send(8'hFF);
      send(8'h11);
      n = 0;
      while (vcount - base != 2 && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check("flush_wait_timeout", 32'(0), 32'(1));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      q_m.delete();
      q_l.delete();
      check_cleared("flush");
      send(8'h80);
      drain();

      // Bypass: next word accepted exactly on the last-bit edge.
      send(8'hA5);
      repeat (8) tick();
      send(8'h3C);
      check("bypass_ready", 32'(in_ready_m), 32'(1));
      check("bypass_busy",  32'(busy_m),     32'(1));
      drain();
      check("bypass_run", 32'(last_run), 32'(16));

      // Same timing, but rst lands on the last-bit edge.
      send(8'hA5);
      repeat (8) tick();
      rst = 1'b1;
      in_valid = 1'b1;
      in_data = 8'h3C;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      q_m.delete();
      q_l.delete();
      check_cleared("rst_last");
      base = vcount;
      repeat (12) tick();
      check("rst_nothing_emitted", 32'(vcount - base), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
